// File: rtl/cchw_pkg.sv
// Shared types and defaults for the octave decimator: sample type, default sizes, FSM states.
package cchw_pkg;

    localparam int unsigned N_DEF   = 16;
    localparam int unsigned OCT_DEF = 5;

    typedef logic signed [N_DEF-1:0] sample_t;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StWaitDft
    } state_e;

endpackage

// File: rtl/octave_decimator_if.sv
// Sample-in / octave-out bundle between the decimator and its producer and octave storages.
interface octave_decimator_if #(
    parameter int unsigned N   = 16,
    parameter int unsigned OCT = 5
);

    logic signed [N-1:0]       inSample;
    logic                      inValid;
    logic                      inReady;
    logic [OCT-1:0][N-1:0]     newSample;
    logic [OCT-1:0]            writeSample;
    logic                      startDft;
    logic                      dftDone;

    // slave is the decimator side; master is the producer / DFT engine side
    modport slave (
        input  inSample, inValid, dftDone,
        output inReady, newSample, writeSample, startDft
    );

    modport master (
        output inSample, inValid, dftDone,
        input  inReady, newSample, writeSample, startDft
    );

endinterface

// File: rtl/pair_averager.sv
// One decimation stage: holds every other input and emits the average of each pair.
// DECIM_ROUND_EN selects round-half-up averaging instead of floor.
module pair_averager #(
    parameter int unsigned N = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_i,
    input  logic signed [N-1:0] data_i,
    output logic                valid_o,
    output logic signed [N-1:0] data_o
);

    logic signed [N-1:0] pend_q, pend_d;
    logic                flag_q, flag_d;
    logic signed [N:0]   sum;
    logic signed [N:0]   sum_adj;

    // One extra bit holds the full pair sum, so neither the sum nor the rounding bias can overflow
    always_comb begin
        sum = {pend_q[N-1], pend_q} + {data_i[N-1], data_i};
`ifdef DECIM_ROUND_EN
        sum_adj = sum + {{N{1'b0}}, 1'b1};
`else
        sum_adj = sum;
`endif
        data_o  = sum_adj[N:1];
        valid_o = valid_i & flag_q;
    end

    always_comb begin
        pend_d = pend_q;
        flag_d = flag_q;
        if (valid_i) begin
            flag_d = ~flag_q;
            if (!flag_q) begin
                pend_d = data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
            flag_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            flag_q <= flag_d;
        end
    end

endmodule

// File: rtl/octave_decimator.sv
// Octave decimator: accepts one sample per pass, cascades pair averages through OCT octaves
// in the transfer cycle, strobes the updated octaves and requests a DFT pass.
module octave_decimator
    import cchw_pkg::*;
#(
    parameter int unsigned N   = N_DEF,
    parameter int unsigned OCT = OCT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    octave_decimator_if.slave  bus
);

    state_e                state_q;
    logic [OCT-1:0]        write_q;
    logic                  start_q;
    logic [OCT-1:0][N-1:0] sample_q;

    logic                  xfer;
    logic                  stage_vld [OCT];
    logic signed [N-1:0]   stage_dat [OCT];
    logic [OCT-1:0]        stage_strobe;

    assign xfer         = (state_q == StIdle) && bus.inValid;
    assign stage_vld[0] = xfer;
    assign stage_dat[0] = bus.inSample;

    // Stage k fires only when stage k-1 fires, so the whole cascade settles in the transfer cycle
    for (genvar k = 1; k < OCT; k++) begin : g_oct
        pair_averager #(
            .N (N)
        ) u_avg (
            .clk     (clk),
            .rst     (rst),
            .valid_i (stage_vld[k-1]),
            .data_i  (stage_dat[k-1]),
            .valid_o (stage_vld[k]),
            .data_o  (stage_dat[k])
        );
    end

    always_comb begin
        stage_strobe = '0;
        for (int k = 0; k < int'(OCT); k++) begin
            stage_strobe[k] = stage_vld[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            write_q  <= '0;
            start_q  <= 1'b0;
            sample_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (xfer) begin
                        state_q <= StWrite;
                        write_q <= stage_strobe;
                        start_q <= 1'b1;
                        for (int k = 0; k < int'(OCT); k++) begin
                            if (stage_strobe[k]) begin
                                sample_q[k] <= stage_dat[k];
                            end
                        end
                    end
                end
                StWrite: begin
                    state_q <= StWaitDft;
                    write_q <= '0;
                    start_q <= 1'b0;
                end
                StWaitDft: begin
                    if (bus.dftDone) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    write_q <= '0;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inReady     = (state_q == StIdle);
    assign bus.writeSample = write_q;
    assign bus.startDft    = start_q;
    assign bus.newSample   = sample_q;

endmodule

// File: tb/tb_octave_decimator.sv
// Self-checking bench for octave_decimator: directed cases plus random samples against a
// history-based octave model; honours DECIM_ROUND_EN for expected averages.
module tb_octave_decimator;
    import cchw_pkg::*;

    localparam int unsigned N   = N_DEF;
    localparam int unsigned OCT = OCT_DEF;

    logic clk;
    logic rst;

    octave_decimator_if #(.N(N), .OCT(OCT)) bus ();

    octave_decimator #(
        .N   (N),
        .OCT (OCT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Reference model: full history of accepted samples since reset
    int hist[$];
    int cnt;
    int exp_ns [OCT];
    logic [OCT-1:0] exp_ws;

    function automatic int avg2(input int a, input int b);
`ifdef DECIM_ROUND_EN
        return (a + b + 1) >>> 1;
`else
        return (a + b) >>> 1;
`endif
    endfunction

    // Value written to octave k on accepted sample c (c a multiple of 2^k)
    function automatic int oct_val(input int k, input int c);
        if (k == 0) return hist[c-1];
        return avg2(oct_val(k - 1, c - (1 << (k - 1))), oct_val(k - 1, c));
    endfunction

    task automatic model_reset();
        hist.delete();
        cnt = 0;
        for (int k = 0; k < int'(OCT); k++) exp_ns[k] = 0;
        exp_ws = '0;
    endtask

    task automatic model_accept(input int s);
        sample_t sv;
        sv = sample_t'(s);
        hist.push_back(int'(sv));
        cnt++;
        exp_ws = '0;
        for (int k = 0; k < int'(OCT); k++) begin
            if (cnt % (1 << k) == 0) begin
                exp_ws[k] = 1'b1;
                exp_ns[k] = oct_val(k, cnt);
            end
        end
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ready"}, 64'(bus.inReady), 64'(1));
        chk({tag, "_ws"}, 64'(bus.writeSample), 64'(0));
        chk({tag, "_sd"}, 64'(bus.startDft), 64'(0));
        for (int k = 0; k < int'(OCT); k++)
            chk($sformatf("%s_ns%0d", tag, k), 64'($signed(bus.newSample[k])), 64'(0));
    endtask

    task automatic chk_write(input int idx);
        chk($sformatf("ws_s%0d", idx), 64'(bus.writeSample), 64'(exp_ws));
        chk($sformatf("sd_s%0d", idx), 64'(bus.startDft), 64'(1));
        chk($sformatf("rdy_wr_s%0d", idx), 64'(bus.inReady), 64'(0));
        for (int k = 0; k < int'(OCT); k++)
            chk($sformatf("ns%0d_s%0d", k, idx), 64'($signed(bus.newSample[k])),
                64'(exp_ns[k]));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk_outputs_zero("reset");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One full pass; hold keeps inValid high through WAIT_DFT, early raises dftDone before transfer
    task automatic pass(input int s, input int dly, input bit hold, input bit early);
        int pulses;
        @(negedge clk);
        chk($sformatf("rdy_idle_s%0d", cnt + 1), 64'(bus.inReady), 64'(1));
        bus.inValid  = 1'b1;
        bus.inSample = N'(s);
        if (early) bus.dftDone = 1'b1;
        @(negedge clk);
        if (!hold) bus.inValid = 1'b0;
        model_accept(s);
        chk_write(cnt);
        pulses = int'(bus.startDft);
        @(negedge clk);
        if (early) begin
            chk($sformatf("rdy_wait_early_s%0d", cnt), 64'(bus.inReady), 64'(0));
        end else begin
            for (int i = 0; i <= dly; i++) begin
                chk($sformatf("rdy_wait_s%0d", cnt), 64'(bus.inReady), 64'(0));
                chk($sformatf("ws_wait_s%0d", cnt), 64'(bus.writeSample), 64'(0));
                pulses += int'(bus.startDft);
                if (i < dly) @(negedge clk);
            end
            bus.dftDone = 1'b1;
        end
        @(negedge clk);
        bus.dftDone = 1'b0;
        bus.inValid = 1'b0;
        chk($sformatf("rdy_back_s%0d", cnt), 64'(bus.inReady), 64'(1));
        chk($sformatf("sd_pulses_s%0d", cnt), 64'(pulses), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        bus.inValid  = 1'b0;
        bus.inSample = '0;
        bus.dftDone  = 1'b0;
        rst = 1'b1;
        #1;
        do_reset();

        // Two samples, then the four-sample averaging example
        pass(100, 0, 1'b0, 1'b0);
        pass(300, 1, 1'b0, 1'b0);
        chk("oct1_after_2", 64'($signed(bus.newSample[1])), 64'(200));
        pass(-500, 0, 1'b0, 1'b0);
        pass(-101, 2, 1'b0, 1'b0);
`ifdef DECIM_ROUND_EN
        chk("oct1_after_4", 64'($signed(bus.newSample[1])), -64'sd300);
        chk("oct2_after_4", 64'($signed(bus.newSample[2])), -64'sd50);
`else
        chk("oct1_after_4", 64'($signed(bus.newSample[1])), -64'sd301);
        chk("oct2_after_4", 64'($signed(bus.newSample[2])), -64'sd51);
`endif

        // inValid held while the DFT pass takes 10 cycles: exactly one transfer
        pass(1234, 10, 1'b1, 1'b0);
        @(negedge clk);
        chk("held_no_extra_ws", 64'(bus.writeSample), 64'(0));
        chk("held_still_idle", 64'(bus.inReady), 64'(1));

        // dftDone high in IDLE and WRITE must not skip WAIT_DFT
        pass(-7, 0, 1'b0, 1'b1);

        // Reset while waiting on the DFT after sample 1
        do_reset();
        @(negedge clk);
        bus.inValid  = 1'b1;
        bus.inSample = N'(55);
        @(negedge clk);
        bus.inValid = 1'b0;
        @(negedge clk);
        chk("pre_rst_wait", 64'(bus.inReady), 64'(0));
        do_reset();
        pass(7, 0, 1'b0, 1'b0);
        chk("post_rst_ns0", 64'($signed(bus.newSample[0])), 64'(7));

        // 32 random samples from reset: octave 4 strobes on samples 16 and 32 only
        do_reset();
        for (int i = 0; i < 32; i++) begin
            pass(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 3)), 1'b0,
                 (i % 7) == 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/octave_decimator.md
OCTAVE_DECIMATOR -- requirements
Module: octave_decimator

Interface
REQ-001 Parameter: N, 16, sample width in bits (signed two's complement).
REQ-002 Parameter: OCT, 5, number of octaves produced.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: inSample  input  N  signed incoming audio sample.
REQ-006 Port: inValid  input  1  inSample is presented this cycle.
REQ-007 Port: inReady  output  1  block accepts a sample this cycle; a sample transfers when inValid && inReady.
REQ-008 Port: newSample  output  OCT x N  per-octave sample feeding each octave storage.
REQ-009 Port: writeSample  output  OCT  per-octave one-cycle write strobe qualifying newSample[k].
REQ-010 Port: startDft  output  1  one-cycle pulse requesting a DFT pass over the updated storages.
REQ-011 Port: dftDone  input  1  DFT pass complete; pulse or level.

Function
REQ-012 States: IDLE, WRITE, WAIT_DFT; inReady SHALL be 1 only in IDLE.
REQ-013 IDLE -> WRITE on transfer; the captured sample is processed in the transfer cycle and results are registered.
REQ-014 WRITE lasts exactly one cycle: writeSample strobes and startDft asserted, then WAIT_DFT.
REQ-015 WAIT_DFT -> IDLE on the first cycle dftDone=1; dftDone SHALL be ignored in IDLE and WRITE.
REQ-016 Octave 0: newSample[0] = accepted sample; writeSample[0] = 1 on every WRITE.
REQ-017 Octave k>=1: holds a pending-half register and flag; when octave k-1 is written, if the flag is clear, store the value and set the flag (no write); if set, write the average of the stored and new values and clear the flag.
REQ-018 The cascade SHALL resolve within one cycle, so octave k is written on every 2^k-th accepted sample (1-based count).
REQ-019 Average = (a + b) >>> 1 computed in N+1 bits, truncated back to N bits; overflow is impossible.
REQ-020 newSample[k] SHALL hold its last written value when not strobed; writeSample is 0 outside WRITE.
REQ-021 inValid while inReady=0 SHALL be ignored with no buffering; a held inValid transfers once per IDLE visit.
REQ-022 Pending flags wrap naturally: after 2^(OCT-1) samples, all flags are clear again.

Reset
REQ-023 On rst=0 (asynchronous): state IDLE, inReady=1, writeSample=0, startDft=0, newSample=0, pending registers and flags cleared.
REQ-024 Reset mid-WRITE or mid-WAIT_DFT SHALL abandon the pass; the next sample is treated as sample 1.

Configuration
REQ-025 Macro DECIM_ROUND_EN defined: average = (a + b + 1) >>> 1 (round half up).
REQ-026 DECIM_ROUND_EN undefined: average = (a + b) >>> 1 (floor); all other behaviour identical.

Structure
REQ-027 Shared package cchw_pkg SHALL hold the sample_t typedef (signed N bits), default N/OCT constants and the state enum.
REQ-028 Sub-module pair_averager (pending register, flag, averaging adder) SHALL be instantiated once per octave k>=1.

Verification
REQ-029 Reset, transfer 100 then 300 (dftDone each pass) -> writeSample[0] 100, 300; second pass also writeSample[1] = 200.
REQ-030 Samples 100, 300, -500, -101 -> oct1 writes 200, -301; oct2 writes -51 on sample 4; with DECIM_ROUND_EN -> oct1 -300, oct2 -50.
REQ-031 inValid held high, dftDone withheld 10 cycles -> exactly one transfer, startDft pulses once, inReady=0 until the cycle after dftDone.
REQ-032 32 consecutive samples -> writeSample[4] first asserts on sample 16, again on sample 32; never on others.
REQ-033 rst asserted in WAIT_DFT after sample 1 -> all outputs zero, inReady=1; next sample 7 -> only writeSample[0] with 7.
REQ-034 dftDone=1 during IDLE and WRITE -> no state change; WAIT_DFT still entered after WRITE.
